// File: rtl/pc_pkg.sv
// Shared types and defaults for the program-counter stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pc_pkg;

  localparam int PC_WIDTH = 16;
  localparam int PC_DEPTH = 8;

  // One operation per cycle, chosen by the priority encoder in pc_stack.
  typedef enum logic [2:0] {
    OP_HOLD = 3'd0,
    OP_CLR  = 3'd1,
    OP_LOAD = 3'd2,
    OP_CALL = 3'd3,
    OP_RET  = 3'd4,
    OP_INC  = 3'd5
  } pc_op_e;

endpackage

// File: rtl/pc_stack_if.sv
// Request/status bundle between the PC stage and whoever drives it.
// Latency: n/a (wires only); status fields are all registered in pc_stack.
// Backpressure: none; a request is consumed on every rising edge.
interface pc_stack_if
  import pc_pkg::*;
#(
  parameter int WIDTH = PC_WIDTH,
  parameter int DEPTH = PC_DEPTH
);
  localparam int LW = $clog2(DEPTH + 1);

  logic             clr;
  logic             load;
  logic             call;
  logic             ret;
  logic             inc;
  logic [WIDTH-1:0] in;
  logic [WIDTH-1:0] out;
  logic [LW-1:0]    level;
  logic             empty;
  logic             full;
  logic             ovf;
  logic             unf;

  modport master (
    output clr, load, call, ret, inc, in,
    input  out, level, empty, full, ovf, unf
  );

  modport slave (
    input  clr, load, call, ret, inc, in,
    output out, level, empty, full, ovf, unf
  );

endinterface

// File: rtl/pc_lifo.sv
// Register-array return-address LIFO; top is the most recent push.
// Latency: push/pop take effect on the next rising edge; top/level are registered state.
// Backpressure: push when full and pop when empty are silently dropped.
module pc_lifo
  import pc_pkg::*;
#(
  parameter int WIDTH = PC_WIDTH,
  parameter int DEPTH = PC_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             top,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         full,
  output logic                         empty
);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [LW-1:0]    level_q;
  logic [IW-1:0]    wr_idx;
  logic [IW-1:0]    rd_idx;
  logic             do_push;
  logic             do_pop;

  // Slots at or above level_q are stale; the index wrap at level 0 / DEPTH
  // is harmless because push/pop are gated off in those states.
  assign wr_idx  = IW'(level_q);
  assign rd_idx  = IW'(level_q - LW'(1));
  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign top     = mem[rd_idx];
  assign level   = level_q;

  // Occupancy counter; flush wins over any push/pop in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= '0;
    end else if (flush) begin
      level_q <= '0;
    end else if (do_push) begin
      level_q <= level_q + LW'(1);
    end else if (do_pop) begin
      level_q <= level_q - LW'(1);
    end
  end

  // Storage is deliberately not reset; only entries below level are ever read.
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_idx] <= din;
    end
  end

endmodule

// File: rtl/pc_stack.sv
// Program counter with call/return stack and sticky overflow/underflow flags.
// Latency: one cycle for every operation; all outputs are registered.
// Backpressure: none; illegal call/ret are absorbed and reported via ovf/unf.
module pc_stack
  import pc_pkg::*;
#(
  parameter int WIDTH = PC_WIDTH,
  parameter int DEPTH = PC_DEPTH
) (
  input  logic       clk,
  input  logic       rst_n,
  pc_stack_if.slave  bus
);
  localparam int LW = $clog2(DEPTH + 1);

  pc_op_e           op;
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_nxt;
  logic [WIDTH-1:0] stk_top;
  logic [LW-1:0]    stk_level;
  logic             stk_full;
  logic             stk_empty;
  logic             stk_push;
  logic             stk_pop;
  logic             stk_flush;
  logic             ovf_q;
  logic             unf_q;

  // Strict priority: clr > load > call > ret > inc > hold.
  always_comb begin
    op = OP_HOLD;
    if (bus.clr) begin
      op = OP_CLR;
    end else if (bus.load) begin
      op = OP_LOAD;
    end else if (bus.call) begin
      op = OP_CALL;
    end else if (bus.ret) begin
      op = OP_RET;
    end else if (bus.inc) begin
      op = OP_INC;
    end
  end

  // Stack controls follow the chosen op only, so ignored requests have no side effects.
  always_comb begin
    stk_flush = (op == OP_CLR);
    stk_push  = (op == OP_CALL) && !stk_full;
    stk_pop   = (op == OP_RET) && !stk_empty;
  end

  // Return address and increment share one adder; wraps mod 2^WIDTH.
  assign pc_nxt = pc_q + WIDTH'(1);

  pc_lifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_lifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (stk_flush),
    .push  (stk_push),
    .pop   (stk_pop),
    .din   (pc_nxt),
    .top   (stk_top),
    .level (stk_level),
    .full  (stk_full),
    .empty (stk_empty)
  );

  // PC register and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      case (op)
        OP_CLR: begin
          pc_q  <= '0;
          ovf_q <= 1'b0;
          unf_q <= 1'b0;
        end
        OP_LOAD: pc_q <= bus.in;
        OP_CALL: begin
          if (stk_full) begin
            ovf_q <= 1'b1;
          end else begin
            pc_q <= bus.in;
          end
        end
        OP_RET: begin
          if (stk_empty) begin
            unf_q <= 1'b1;
          end else begin
            pc_q <= stk_top;
          end
        end
        OP_INC:  pc_q <= pc_nxt;
        default: pc_q <= pc_q;
      endcase
    end
  end

  assign bus.out   = pc_q;
  assign bus.level = stk_level;
  assign bus.empty = stk_empty;
  assign bus.full  = stk_full;
  assign bus.ovf   = ovf_q;
  assign bus.unf   = unf_q;

endmodule

// File: doc/pc_stack.md
# pc_stack

Width-parametrised program counter with a call/return stack. It is the sequential successor to the team's combinational gate primitives and forms the instruction-address stage of the CPU datapath. Each cycle it holds, clears, loads, increments, calls (push return address and jump) or returns (pop and jump). It flags stack overflow and underflow with sticky error bits.

## Interface
- `WIDTH`, default 16: address width in bits.
- `DEPTH`, default 8: return-stack entries; must be ≥ 2.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `clr` input 1: synchronous clear.
- `load` input 1: jump to `in`.
- `call` input 1: push `out+1`, then jump to `in`.
- `ret` input 1: pop the top entry into `out`.
- `inc` input 1: `out <= out+1`.
- `in` input WIDTH: jump/call target.
- `out` output WIDTH: current PC; registered.
- `level` output clog2(DEPTH+1): stack occupancy, 0..DEPTH.
- `empty` output 1: `level==0`.
- `full` output 1: `level==DEPTH`.
- `ovf` output 1: sticky; a call was attempted while full.
- `unf` output 1: sticky; a ret was attempted while empty.

## Operation
- One operation per cycle. Priority is strict: clr > load > call > ret > inc > hold. Lower-priority requests in the same cycle are ignored with no side effects.
- **clr:** `out=0`, `level=0`, `ovf=0`, `unf=0`.
- **load:** `out=in`. The stack is untouched.
- **call, not full:** `stack[level] = out+1` (mod 2^WIDTH), `level+1`, `out=in`.
- **call, full:** no push, `out` unchanged, `level` unchanged, `ovf=1`.
- **ret, not empty:** `out=stack[level-1]`, `level-1`.
- **ret, empty:** `out` unchanged, `unf=1`.
- **inc:** `out=out+1`. It wraps from 2^WIDTH-1 to 0 with no flag.
- **Arithmetic:** all adds are unsigned, mod 2^WIDTH. A call at `out=2^WIDTH-1` pushes 0.
- **Sticky flags:** `ovf` and `unf` stay set until clr or reset. Operation continues normally while they are set.
- **Unused slots:** stack entries at index ≥ `level` are don't-care and must never appear on `out`.

## Timing
- **Reset:** `rst_n` low immediately forces `out=0`, `level=0`, `ovf=0`, `unf=0`, `empty=1`, `full=0`. Stack contents are not reset.
- **Reset mid-operation:** any request in flight is discarded. The first edge with `rst_n` high performs the operation presented on that edge.
- **Latency:** one cycle for every operation. The result is visible on `out` after the rising edge that samples the request.
- **Back-to-back:** call then ret on consecutive cycles is supported. ret returns the value pushed one edge earlier.
- **Flags:** `empty`, `full` and `level` are registered-consistent, i.e. derived from the registered `level` only, with no combinational path from the inputs.
- **Outputs:** no combinational input-to-output paths.

## Structure
- **Shared package `pc_pkg`:** op-select enum `OP_HOLD`, `OP_CLR`, `OP_LOAD`, `OP_CALL`, `OP_RET`, `OP_INC`; default `WIDTH`/`DEPTH` constants. The priority encoder in `pc_stack` produces this enum.
- **Sub-module `pc_lifo`** (`WIDTH`, `DEPTH`): register-array LIFO with `push`, `pop`, `din`, `top`, `level`, `full`, `empty`, and the same `clk`/`rst_n`. It ignores push-when-full and pop-when-empty; `pc_stack` owns `ovf`/`unf` and the `out` register.

## Test plan
- **Reset and wrap:** reset, then 3 inc → `out=3`, `empty=1`. Load 16'hFFFF, inc → `out=0`, no flag.
- **Call/return:** load 16'h0100, call `in`=16'h2000 → `out=16'h2000`, `level=1`. Call 16'h3000 → `level=2`. ret → `out=16'h2001`. ret → `out=16'h0101`, `empty=1`.
- **Overflow:** DEPTH=8; 8 calls → `full=1`. 9th call → `out` unchanged, `level=8`, `ovf=1`. 8 rets then pop the correct 8 addresses in LIFO order.
- **Underflow and clear:** ret on empty → `out` unchanged, `unf=1`. clr → `out=0`, `unf=0`, `ovf=0`.
- **Priority:** with a stack entry present, assert load+call+ret+inc with `in`=16'h0042 → `out=16'h0042`, `level` unchanged. Assert call+ret → a push occurs.
- **Async reset:** drop `rst_n` between edges with `level=3` → `out=0`, `level=0` immediately. Release, then inc → `out=1`.
